// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: device end of the host-initiated serial register protocol.
// Pulls fixed-length W/R frames from the RX FIFO, executes them against a local
// register file and pushes exactly one reply byte per frame into the TX FIFO.
module uart_cmd_responder #(
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 208320
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_empty,
    output logic                  rx_rd_en,
    output logic [7:0]            tx_data,
    input  logic                  tx_full,
    output logic                  tx_wr_en,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  busy,
    output logic [7:0]            err_cnt
);
    localparam int          AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0]  CMD_W   = 8'h57;
    localparam logic [7:0]  CMD_R   = 8'h52;
    localparam logic [7:0]  RSP_OK  = 8'h4B;
    localparam logic [7:0]  RSP_UNK = 8'h3F;
    localparam logic [7:0]  RSP_ERR = 8'h45;
    // the idle cycle that would take the counter to TIMEOUT_CYCLES ends the frame
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, WAIT_ADDR, ADDR, WAIT_DATA, DATA, RESP
    } state_t;

    state_t                   state;
    logic                     is_wr;
    logic                     addr_ok;
    logic [AW-1:0]            addr;
    logic [31:0]              wait_cnt;
    logic [NUM_REGS-1:0][7:0] regs;
    logic                     in_wait;
    logic                     addr_in_range;
    logic                     timeout;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_wait       = (state == WAIT_ADDR) || (state == WAIT_DATA);
    assign addr_in_range = {1'b0, rx_data} < 9'(NUM_REGS);
    assign timeout       = in_wait && rx_empty && (wait_cnt == TO_LAST);

    // FIFO strobes are decoded from the registered state and the same-cycle
    // flags, so a pop/push can never be issued against an empty/full FIFO;
    // every fetch state is followed by a capture state, so pops are >= 2 apart.
    assign rx_rd_en  = rst && !rx_empty && ((state == IDLE) || in_wait);
    assign tx_wr_en  = (state == RESP) && !tx_full;
    assign busy      = (state != IDLE);
    assign regs_flat = regs;

    // frame sequencer: state, captured command/address, reply byte, regs, error count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            is_wr    <= 1'b0;
            addr_ok  <= 1'b0;
            addr     <= '0;
            wait_cnt <= '0;
            tx_data  <= '0;
            err_cnt  <= '0;
            regs     <= '0;
        end else begin
            case (state)
                IDLE: if (!rx_empty) state <= CMD;
                CMD: begin
                    is_wr <= (rx_data == CMD_W);
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        wait_cnt <= '0;
                        state    <= WAIT_ADDR;
                    end else begin
                        tx_data <= RSP_UNK;
                        err_cnt <= sat_inc(err_cnt);
                        state   <= RESP;
                    end
                end
                WAIT_ADDR, WAIT_DATA: begin
                    if (!rx_empty) begin
                        state <= (state == WAIT_ADDR) ? ADDR : DATA;
                    end else if (timeout) begin
                        // partial frame dropped silently, only counted
                        err_cnt <= sat_inc(err_cnt);
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ADDR: begin
                    addr    <= rx_data[AW-1:0];
                    addr_ok <= addr_in_range;
                    if (is_wr) begin
                        wait_cnt <= '0;
                        state    <= WAIT_DATA;
                    end else begin
                        state <= RESP;
                        if (addr_in_range) begin
                            tx_data <= regs[rx_data[AW-1:0]];
                        end else begin
                            tx_data <= RSP_ERR;
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end
                DATA: begin
                    // a bad-address write still consumes its data byte
                    if (addr_ok) begin
                        regs[addr] <= rx_data;
                        tx_data    <= RSP_OK;
                    end else begin
                        tx_data <= RSP_ERR;
                        err_cnt <= sat_inc(err_cnt);
                    end
                    state <= RESP;
                end
                RESP: if (!tx_full) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: FIFO models on both sides, a
// frame-level reference model and a reply/latency scoreboard.
module tb_uart_cmd_responder;
    localparam int NR = 16;
    localparam int TO = 40;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_empty = 1'b1;
    logic            rx_rd_en;
    logic [7:0]      tx_data;
    logic            tx_full = 1'b0;
    logic            tx_wr_en;
    logic [8*NR-1:0] regs_flat;
    logic            busy;
    logic [7:0]      err_cnt;

    uart_cmd_responder #(.NUM_REGS(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_rd_en(rx_rd_en), .tx_data(tx_data), .tx_full(tx_full),
        .tx_wr_en(tx_wr_en), .regs_flat(regs_flat), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    logic [7:0] rx_q[$], got_q[$], exp_q[$];
    int         lat_q[$], elat_q[$], wr_q[$];
    logic [7:0] m_regs[NR];
    int         m_err = 0;
    int         cyc = 0, start_cyc = 0, rd_bad = 0, wr_bad = 0;
    logic       pop_s = 1'b0, rd_prev = 1'b0, rnd_bp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // bus monitor: protocol rules, reply capture, per-frame latency
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pop_s   = 1'b0;
            rd_prev = 1'b0;
        end else begin
            if (rx_rd_en) begin
                if (rx_empty || rd_prev) rd_bad++;
                if (!busy) start_cyc = cyc;
            end
            rd_prev = rx_rd_en;
            pop_s   = rx_rd_en;
            if (tx_wr_en) begin
                if (tx_full) wr_bad++;
                got_q.push_back(tx_data);
                lat_q.push_back(cyc - start_cyc + 1);
                wr_q.push_back(cyc);
            end
        end
    end

    // RX FIFO: popped data appears the cycle after rx_rd_en
    initial forever begin
        @(posedge clk);
        #1;
        if (pop_s && rx_q.size() > 0) rx_data = rx_q.pop_front();
        rx_empty = (rx_q.size() == 0);
    end

    // random TX back-pressure
    initial forever begin
        tick();
        if (rnd_bp) tx_full = ($urandom_range(0, 2) == 0);
    end

    function automatic void bump();
        if (m_err < 255) m_err++;
    endfunction

    // reference: what a frame of nb delivered bytes must produce
    function automatic void model(input logic [7:0] c, input logic [7:0] a,
                                  input logic [7:0] d, input int nb);
        if (c != 8'h57 && c != 8'h52) begin
            exp_q.push_back(8'h3F);
            elat_q.push_back(3);
            bump();
            return;
        end
        if (nb < ((c == 8'h57) ? 3 : 2)) begin
            bump();
            return;
        end
        elat_q.push_back((c == 8'h57) ? 7 : 5);
        if (int'(a) >= NR) begin
            exp_q.push_back(8'h45);
            bump();
        end else if (c == 8'h57) begin
            m_regs[int'(a)] = d;
            exp_q.push_back(8'h4B);
        end else begin
            exp_q.push_back(m_regs[int'(a)]);
        end
    endfunction

    task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                        input int nb, input int maxgap);
        logic [7:0] b[3];
        int len, n;
        b[0] = c; b[1] = a; b[2] = d;
        len = (c == 8'h57) ? 3 : (c == 8'h52) ? 2 : 1;
        n = (nb < len) ? nb : len;
        model(c, a, d, n);
        tick();
        for (int i = 0; i < n; i++) begin
            rx_q.push_back(b[i]);
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(rx_q.size() == 0 && rx_empty && !busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(n < 5000), 32'd1);
    endtask

    task automatic drain(input string tag, input bit lat);
        wait_idle(tag);
        repeat (3) @(negedge clk);
        chk({tag, "_nrep"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_rep"}, got_q.pop_front(), exp_q.pop_front());
        if (lat)
            while (lat_q.size() > 0 && elat_q.size() > 0)
                chk({tag, "_lat"}, lat_q.pop_front(), elat_q.pop_front());
        chk({tag, "_err"}, err_cnt, m_err);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s_reg%0d", tag, i), regs_flat[8*i +: 8], m_regs[i]);
        got_q.delete(); exp_q.delete(); lat_q.delete(); elat_q.delete(); wr_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, exp0;
        int r, nwr, nidle, nrd, nchg, bad;
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        repeat (3) tick();
        chk("rst_rd", rx_rd_en, 0);
        chk("rst_wr", tx_wr_en, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_regs", 32'(regs_flat == '0), 1);
        rst = 1'b1;
        tick();

        // write then read back
        send(8'h57, 8'h03, 8'hA5, 3, 0);
        send(8'h52, 8'h03, 8'h00, 2, 0);
        drain("wr_rd", 1'b1);
        chk("wr_rd_reg3", regs_flat[31:24], 8'hA5);

        // unknown command, bad read address, bad write address
        send(8'h41, 8'h00, 8'h00, 1, 0);
        send(8'h52, 8'h10, 8'h00, 2, 0);
        send(8'h57, 8'h20, 8'hFF, 3, 0);
        drain("bad", 1'b1);
        chk("bad_err3", err_cnt, 3);

        // partial write times out silently, following read unaffected
        send(8'h57, 8'h05, 8'h99, 2, 0);
        repeat (TO + 10) tick();
        send(8'h52, 8'h05, 8'h00, 2, 0);
        drain("tmo", 1'b1);

        // TX back-pressure with a byte queued behind the frame
        tx_full = 1'b1;
        exp0 = m_regs[0];
        send(8'h52, 8'h00, 8'h00, 2, 0);
        send(8'h41, 8'h00, 8'h00, 1, 0);
        repeat (8) tick();
        nwr = 0; nidle = 0; nrd = 0; nchg = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_wr_en) nwr++;
            if (!busy) nidle++;
            if (rx_rd_en) nrd++;
            if (tx_data !== exp0) nchg++;
        end
        chk("bp_wr", nwr, 0);
        chk("bp_idle", nidle, 0);
        chk("bp_rd", nrd, 0);
        chk("bp_txd_hold", nchg, 0);
        tick();
        tx_full = 1'b0;
        @(negedge clk);
        chk("bp_rel_wr", tx_wr_en, 1);
        chk("bp_rel_txd", tx_data, exp0);
        drain("bp", 1'b0);

        // reset in the middle of a write frame
        tick();
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h02);
        repeat (8) tick();
        rst = 1'b0;
        #1;
        chk("mrst_rd", rx_rd_en, 0);
        chk("mrst_wr", tx_wr_en, 0);
        chk("mrst_txd", tx_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_err", err_cnt, 0);
        chk("mrst_regs", 32'(regs_flat == '0), 1);
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_err = 0;
        rx_q.delete(); got_q.delete(); exp_q.delete();
        lat_q.delete(); elat_q.delete(); wr_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        send(8'h52, 8'h02, 8'h00, 2, 0);
        drain("mrst", 1'b1);

        // randomized frames, gaps and back-pressure
        rnd_bp = 1'b1;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40) c = 8'h57;
            else if (r < 80) c = 8'h52;
            else begin
                c = 8'($urandom);
                while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
            end
            if (c inside {8'h57, 8'h52} && $urandom_range(0, 9) == 0) begin
                drain("rnd", 1'b0);
                send(c, 8'($urandom_range(0, 19)), 8'($urandom),
                     (c == 8'h57) ? $urandom_range(1, 2) : 1, 0);
                drain("rnd_tmo", 1'b0);
            end else begin
                send(c, 8'($urandom_range(0, 19)), 8'($urandom), 3, $urandom_range(0, 6));
            end
        end
        drain("rnd", 1'b0);
        rnd_bp = 1'b0;
        tick();
        tx_full = 1'b0;

        // saturation and back-to-back throughput
        tick();
        for (int i = 0; i < 300; i++) begin
            model(8'h41, 8'h00, 8'h00, 1);
            rx_q.push_back(8'h41);
        end
        wait_idle("sat");
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 1; i < wr_q.size(); i++)
            if (wr_q[i] - wr_q[i-1] != 3) bad++;
        chk("sat_spacing", bad, 0);
        drain("sat", 1'b1);
        chk("sat_err", err_cnt, 8'hFF);

        chk("rd_proto", rd_bad, 0);
        chk("wr_proto", wr_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
